dm_sized: RTL
=============

Name: dm_sized

Overview:
Parametrised data memory for the MIPS datapath. It replaces the word-only data memory and adds:
- byte, halfword and word access (lb/lbu/lh/lhu/sb/sh/sw);
- alignment checking;
- a configurable depth;
- a sequential clear engine that zeroes memory one word per cycle after reset, instead of an all-at-once clear.

Reads are combinational, so the single-cycle datapath is unchanged. Stores commit on the clock edge.

Parameters:
DEPTH, 1024, number of 32-bit words; must be a power of 2 and at least 4
CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = contents retained across reset
IDX_W, $clog2(DEPTH), derived word-index width; not to be overridden

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
Addr  in  32  byte address
in  in  32  store data; the relevant bits are right-aligned (sb uses in[7:0], sh uses in[15:0])
WrEn  in  1  store request
Size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
Unsigned  in  1  1 = zero-extend sub-word loads; 0 = sign-extend
out  out  32  load data, extended to 32 bits
misalign  out  1  combinational access-fault flag
busy  out  1  clear sweep in progress; memory inaccessible

Behaviour:
- Interface (already decided): one clock `clock`; `reset` is synchronous and active-high.
- Word index is Addr[IDX_W+1:2]. Addr bits above IDX_W+1 are ignored, so the address space aliases.
- Lane numbering is little-endian: lane k = word bits [8k+7:8k], selected by Addr[1:0].
- States: IDLE, CLEAR. Registered clr_idx [IDX_W-1:0].
- Reset at a posedge with CLEAR_ON_RESET=1:
  - state <= CLEAR, clr_idx <= 0;
  - busy = 1 from the following cycle.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- Reset at a posedge with CLEAR_ON_RESET=0:
  - state <= IDLE; memory contents are untouched.
- CLEAR state:
  - each posedge writes mem[clr_idx] <= 0 and increments clr_idx;
  - when clr_idx == DEPTH-1 is written, state <= IDLE;
  - busy is high for exactly DEPTH cycles after reset deasserts.
- busy is a direct decode of state == CLEAR. Reset value: 1 if CLEAR_ON_RESET, else 0.
- While busy:
  - WrEn is ignored (no store, no queuing);
  - out = 0;
  - misalign = 0.
- misalign is combinational and evaluated only when not busy:
  - Size=01 with Addr[0]=1;
  - Size=10 with Addr[1:0]!=0;
  - Size=11 regardless of address.
  - It is asserted regardless of WrEn, so a load fault is visible too.
- Store (WrEn=1, not busy, misalign=0), at posedge:
  - byte: lane Addr[1:0] <= in[7:0];
  - half: lanes {Addr[1],0} and {Addr[1],1} <= in[15:0], low byte in the lower lane;
  - word: all lanes <= in.
  - Lanes not selected are preserved bit-exactly.
- Misaligned store is dropped: memory is unchanged and no partial write occurs.
- Load (always active when not busy):
  - byte: lane Addr[1:0] extended per Unsigned;
  - half: lanes as for store, extended per Unsigned;
  - word: the full word.
  - When misalign=1, out = 0.
- Same-cycle store and load to the same word: out shows the old contents until the edge, then the new contents.
- Initial contents with CLEAR_ON_RESET=0 and no reset applied are 0 (simulation initialiser).

Decomposition:
- Shared package dm_pkg holds:
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_ILLEGAL constants;
  - the dm_state_t enum {IDLE, CLEAR}.
- Sub-module dm_lane_align is purely combinational and does two things:
  - maps Size, Addr[1:0], in into a 4-bit byte-enable plus lane-replicated write data;
  - extracts and extends load data from a 32-bit word.
- The top level holds the memory array, the FSM and clr_idx.

Test Plan:
- Sweep timing: DEPTH=16, CLEAR_ON_RESET=1; pre-fill all words with 0xFFFFFFFF, pulse reset for 1 cycle -> busy high exactly 16 cycles, then every word reads 0.
- Reset mid-sweep: reset re-asserted at cycle 7 of the sweep -> sweep restarts, busy stays high 16 more cycles after the deassert.
- Byte stores: sw 0x11223344 @0x8; sb 0xAB @0xA -> word 0x11AB3344.
  - lb @0xA = 0xFFFFFFAB; lbu @0xA = 0x000000AB.
- Halfword access: sh 0x8001 @0x6 -> lh @0x6 = 0xFFFF8001, lhu = 0x00008001; lanes 0-1 of word 1 unchanged.
- Misaligned store dropped: sw 0xDEADBEEF @0x5 -> misalign=1, memory unchanged, out=0.
  - sh @0x3 and Size=11 @0x0 -> misalign=1.
- Store during sweep and aliasing: WrEn during busy -> no effect after the sweep.
  - DEPTH=16: sw 0x5A5A5A5A @0x40 -> visible at @0x0.
  - Same-cycle store+load shows the old value before the edge and the new value after.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared access-size encodings and controller state for the sized data memory
package dm_pkg;
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
  typedef enum logic {IDLE, CLEAR} dm_state_t;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-enable/write-lane replication for stores and lane extraction/extension for loads
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        zext,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rdata,
  output logic        fault
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    fault = size == SIZE_ILLEGAL || (size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'b00);
    // faulting accesses enable no lanes, so a misaligned store can never partially commit
    be = fault ? 4'b0000 : size == SIZE_BYTE ? 4'b0001 << lane : size == SIZE_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    b = rword[8*lane +: 8];
    h = lane[1] ? rword[31:16] : rword[15:0];
    rdata = fault ? '0 : size == SIZE_BYTE ? {{24{b[7] & ~zext}}, b} : size == SIZE_HALF ? {{16{h[15] & ~zext}}, h} : rword;
  end
endmodule

// File: rtl/dm_sized.sv
// dm_sized: sized byte/half/word data memory with alignment checks and a one-word-per-cycle clear sweep
module dm_sized
  import dm_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] in,
  input  logic        WrEn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] out,
  output logic        misalign,
  output logic        busy
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  dm_state_t state = IDLE;
  logic [IDX_W-1:0] clr_idx = '0;
  logic [IDX_W-1:0] widx;
  logic [3:0] be;
  logic [31:0] wrep, rdata;
  logic fault;
  logic unused_addr;
  assign widx = Addr[IDX_W+1:2];
  assign unused_addr = ^Addr[31:IDX_W+2];
  assign busy = state == CLEAR;
  assign out = busy ? '0 : rdata;
  assign misalign = busy ? 1'b0 : fault;
  dm_lane_align u_align (
    .size  (Size),
    .lane  (Addr[1:0]),
    .wdata (in),
    .rword (mem[widx]),
    .zext  (Unsigned),
    .be    (be),
    .wrep  (wrep),
    .rdata (rdata),
    .fault (fault)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == IDX_W'(DEPTH - 1)) state <= IDLE;
    end else if (WrEn) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[widx][8*k +: 8] <= wrep[8*k +: 8];
    end
  end
endmodule
